// File: rtl/shift_sequencer.sv
// Command sequencer for the 8-bit load/shift register: load, shift n times, capture, return result.
// Optional macro SHIFT_SEQ_ZERO_SKIP_EN: zero-count commands bypass the shifter and complete at accept.
module shift_sequencer #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic [CNT_W-1:0] cmd_count,
   input  logic             cmd_asr,
   output logic             sh_load_n,
   output logic             sh_shift,
   output logic             sh_asr_in,
   output logic [WIDTH-1:0] sh_load_val,
   input  logic [WIDTH-1:0] sh_q,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_data
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_LOAD    = 3'd1;
   localparam logic [2:0] S_SHIFT   = 3'd2;
   localparam logic [2:0] S_CAPTURE = 3'd3;
   localparam logic [2:0] S_DONE    = 3'd4;

   logic [2:0]       state;
   logic [2:0]       state_nxt;
   logic [CNT_W-1:0] rem;
   logic             asr_q;
   logic [WIDTH-1:0] data_q;
   logic             accept;
   logic [CNT_W-1:0] count_clamped;

   function automatic logic [CNT_W-1:0] clamp_count(input logic [CNT_W-1:0] c);
      if (int'(c) > WIDTH) return CNT_W'(WIDTH);
      return c;
   endfunction

   // cmd_ready is forced low while reset is held so nothing is accepted during reset
   assign cmd_ready     = (state == S_IDLE) && reset_n;
   assign accept        = cmd_valid && cmd_ready;
   assign count_clamped = clamp_count(cmd_count);

   assign sh_load_n   = (state != S_LOAD);
   assign sh_shift    = (state == S_SHIFT);
   assign sh_asr_in   = (state != S_IDLE) && asr_q;
   assign sh_load_val = data_q;
   assign res_valid   = (state == S_DONE);

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (accept) begin
`ifdef SHIFT_SEQ_ZERO_SKIP_EN
               state_nxt = (count_clamped == '0) ? S_DONE : S_LOAD;
`else
               state_nxt = S_LOAD;
`endif
            end
         end
         S_LOAD:    state_nxt = (rem != '0) ? S_SHIFT : S_CAPTURE;
         // rem==1 here means this cycle drives the final shift edge
         S_SHIFT:   if (rem == CNT_W'(1)) state_nxt = S_CAPTURE;
         S_CAPTURE: state_nxt = S_DONE;
         S_DONE:    if (res_ready) state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= S_IDLE;
         rem      <= '0;
         asr_q    <= 1'b0;
         data_q   <= '0;
         res_data <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  data_q <= cmd_data;
                  asr_q  <= cmd_asr;
                  rem    <= count_clamped;
`ifdef SHIFT_SEQ_ZERO_SKIP_EN
                  if (count_clamped == '0) res_data <= cmd_data;
`endif
               end
            end
            S_SHIFT:   rem <= rem - CNT_W'(1);
            S_CAPTURE: res_data <= sh_q;
            default:   ;
         endcase
      end
   end

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: drives a behavioural load/shift register and checks results
// against a plain-arithmetic shift model, plus latency, handshake and reset behaviour.
module tb_shift_sequencer;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [7:0] cmd_data;
   logic [3:0] cmd_count;
   logic       cmd_asr;
   logic       sh_load_n;
   logic       sh_shift;
   logic       sh_asr_in;
   logic [7:0] sh_load_val;
   logic [7:0] sh_q;
   logic       res_valid;
   logic       res_ready;
   logic [7:0] res_data;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   shift_sequencer #(.WIDTH(8), .CNT_W(4)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_data    (cmd_data),
      .cmd_count   (cmd_count),
      .cmd_asr     (cmd_asr),
      .sh_load_n   (sh_load_n),
      .sh_shift    (sh_shift),
      .sh_asr_in   (sh_asr_in),
      .sh_load_val (sh_load_val),
      .sh_q        (sh_q),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .res_data    (res_data)
   );

   // load/shift register downstream of the sequencer
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n)        sh_q <= 8'h00;
      else if (!sh_load_n) sh_q <= sh_load_val;
      else if (sh_shift)   sh_q <= {sh_asr_in & sh_q[7], sh_q[7:1]};
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_reset_outputs(input string pfx);
      check({pfx, "_load_n"},    32'(sh_load_n),   32'd1);
      check({pfx, "_shift"},     32'(sh_shift),    32'd0);
      check({pfx, "_asr_in"},    32'(sh_asr_in),   32'd0);
      check({pfx, "_load_val"},  32'(sh_load_val), 32'd0);
      check({pfx, "_res_valid"}, 32'(res_valid),   32'd0);
      check({pfx, "_res_data"},  32'(res_data),    32'd0);
      check({pfx, "_cmd_ready"}, 32'(cmd_ready),   32'd0);
   endtask

   // Called and returns at a negedge. hold = extra cycles res_ready stays low in DONE.
   task automatic run_cmd(input logic [7:0] d, input logic [3:0] c, input logic a, input int hold);
      int n;
      int k;
      int loads;
      int shifts;
      int waited;
      int exp_k;
      int exp_loads;
      logic signed [7:0] sd;
      logic [7:0] exp_res;
      logic seen;
      logic asr_bad;
      logic lv_bad;
      logic [7:0] held;

      n = (c > 4'd8) ? 8 : int'(c);
      if (a) begin
         sd = d;
         sd = sd >>> n;
         exp_res = sd;
      end else begin
         exp_res = d >> n;
      end
      exp_k = n + 2;
      exp_loads = 1;
`ifdef SHIFT_SEQ_ZERO_SKIP_EN
      if (n == 0) begin
         exp_k = 0;
         exp_loads = 0;
      end
`endif

      cmd_data = d; cmd_count = c; cmd_asr = a; cmd_valid = 1'b1; res_ready = 1'b0;
      waited = 0;
      while (!cmd_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (!cmd_ready) begin
         check("accept_timeout", 32'd0, 32'd1);
         cmd_valid = 1'b0;
         return;
      end
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_data = ~d;

      k = 0; loads = 0; shifts = 0; seen = 1'b0; asr_bad = 1'b0; lv_bad = 1'b0;
      while (k < 30) begin
         if (!sh_load_n) begin
            loads++;
            if (sh_load_val !== d) lv_bad = 1'b1;
         end
         if (sh_shift) shifts++;
         if (sh_asr_in !== a) asr_bad = 1'b1;
         if (res_valid) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk);
         k++;
      end
      check("res_valid_seen", 32'(seen), 32'd1);
      if (!seen) return;
      check("valid_latency", 32'(k),       32'(exp_k));
      check("load_cycles",   32'(loads),   32'(exp_loads));
      check("shift_cycles",  32'(shifts),  32'(n));
      check("res_data",      32'(res_data), 32'(exp_res));
      check("asr_in_follow", 32'(asr_bad), 32'd0);
      check("load_val",      32'(lv_bad),  32'd0);
      check("done_cmd_ready", 32'(cmd_ready), 32'd0);

      held = res_data;
      for (int h = 0; h < hold; h++) begin
         cmd_valid = 1'b1;
         cmd_data = 8'hA5;
         cmd_count = 4'd2;
         @(negedge clk);
         check("hold_res_valid", 32'(res_valid), 32'd1);
         check("hold_res_data",  32'(res_data),  32'(held));
         check("hold_cmd_ready", 32'(cmd_ready), 32'd0);
         check("hold_load_n",    32'(sh_load_n), 32'd1);
      end
      cmd_valid = 1'b0;

      res_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      res_ready = 1'b0;
      check("post_done_cmd_ready", 32'(cmd_ready), 32'd1);
      check("post_done_res_valid", 32'(res_valid), 32'd0);
   endtask

   task automatic reset_mid_shift();
      int guard;
      cmd_data = 8'hC3; cmd_count = 4'd5; cmd_asr = 1'b1; cmd_valid = 1'b1; res_ready = 1'b1;
      guard = 0;
      while (!cmd_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      check("rst_accept_ready", 32'(cmd_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("rst_second_shift", 32'(sh_shift), 32'd1);
      #2 reset_n = 1'b0;
      #1 check_reset_outputs("midrst");
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         check("post_rst_no_valid", 32'(res_valid), 32'd0);
         check("post_rst_idle_shift", 32'(sh_shift), 32'd0);
      end
      res_ready = 1'b0;
   endtask

   initial begin
      logic [7:0] rd;
      logic [3:0] rc;
      logic       ra;
      reset_n = 1'b0; cmd_valid = 1'b0; cmd_data = 8'h00; cmd_count = 4'd0;
      cmd_asr = 1'b0; res_ready = 1'b0;
      #12 check_reset_outputs("por");
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check("ready_after_release", 32'(cmd_ready), 32'd1);

      run_cmd(8'h96, 4'd3,  1'b0, 0);
      run_cmd(8'h96, 4'd3,  1'b1, 0);
      run_cmd(8'h96, 4'd12, 1'b1, 0);
      run_cmd(8'h96, 4'd12, 1'b0, 0);
      run_cmd(8'h5A, 4'd0,  1'b0, 0);
      run_cmd(8'h5A, 4'd0,  1'b1, 5);
      run_cmd(8'h81, 4'd8,  1'b1, 5);
      run_cmd(8'h81, 4'd15, 1'b0, 1);

      reset_mid_shift();
      run_cmd(8'h96, 4'd3, 1'b1, 0);

      for (int i = 0; i < 40; i++) begin
         rd = 8'($urandom);
         rc = 4'($urandom_range(0, 15));
         ra = 1'($urandom);
         run_cmd(rd, rc, ra, int'($urandom_range(0, 3)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Command-driven controller sitting directly upstream of the team's 8-bit load/shift register. It accepts a byte plus a shift count and an arithmetic flag over a valid/ready handshake, drives the register's load, shift and ASR controls for exactly the requested number of cycles, and then captures the register's parallel output. The captured value is returned on a valid/ready result port. This replaces hand-driven KEY pushes with a deterministic, bench-checkable sequence.

## Interface
- WIDTH, 8, data width; must match the shifter.
- CNT_W, 4, width of the shift-count field.
- clk  in  1  rising-edge clock, shared with the shifter.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_data  in  WIDTH  value to load into the shifter.
- cmd_count  in  CNT_W  number of right shifts; values > WIDTH are clamped to WIDTH.
- cmd_asr  in  1  1 = arithmetic (MSB replicate), 0 = logical (zero fill).
- sh_load_n  out  1  shifter parallel-load enable, active low.
- sh_shift  out  1  shifter shift enable.
- sh_asr_in  out  1  shifter ASR select.
- sh_load_val  out  WIDTH  shifter parallel-load value.
- sh_q  in  WIDTH  shifter parallel output.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- res_data  out  WIDTH  captured shifter value.

## Operation
- FSM has five states: IDLE, LOAD, SHIFT, CAPTURE, DONE. All outputs are Moore (a function of state and the latched command only).
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready, latch data, the clamped count (rem) and asr, then go to LOAD.
- LOAD:
  - sh_load_n=0, sh_load_val=latched data, sh_shift=0.
  - Next state is SHIFT if rem≠0, else CAPTURE.
- SHIFT:
  - sh_load_n=1, sh_shift=1.
  - rem decrements each cycle; go to CAPTURE when rem==1 on the current cycle.
  - This gives exactly rem shift edges.
- CAPTURE:
  - sh_load_n=1, sh_shift=0.
  - res_data<=sh_q at the end of the cycle; go to DONE.
- DONE:
  - res_valid=1; res_data is held stable.
  - On res_ready, go to IDLE.
- sh_asr_in equals the latched asr in every non-IDLE state and 0 in IDLE.
- sh_load_val holds the latched data until the next accept.
- cmd_ready=0 in all states except IDLE, so one command is in flight at a time.
- Commands arriving outside IDLE are not accepted; the source must hold them.

## Timing
- Reset (asynchronous, immediate): state=IDLE, rem=0, asr latch=0, res_data=0, res_valid=0, sh_load_n=1, sh_shift=0, sh_asr_in=0, sh_load_val=0.
- cmd_ready=0 while reset_n is low and 1 from the first cycle after release.
- Define E0 as the accept edge. The load occurs at E1, shifts occur at E2..E(n+1), and the capture occurs at E(n+2). res_valid is high from E(n+2), where n is the clamped count.
- n=0: res_valid rises at E2 and res_data = cmd_data.
- Result handshake completes on the edge where res_valid&res_ready are both high. The earliest next accept is the following edge, so the back-to-back command period is n+4 cycles.
- res_ready held high: DONE lasts exactly one cycle.
- res_ready low: DONE persists indefinitely with no change to any output.
- reset_n asserted mid-operation: the command in flight is dropped, no result is produced, and the shifter controls return to idle values immediately.
- The shifter must share clk and be released from reset with this block.

## Configuration
- Macro: SHIFT_SEQ_ZERO_SKIP_EN.
- Defined:
  - A command with clamped count 0 skips LOAD and CAPTURE and goes IDLE→DONE.
  - res_data<=cmd_data at E0 and res_valid is high from E0.
  - The shifter is not touched: sh_load_n stays 1.
- Undefined: count 0 goes through LOAD→CAPTURE as described above (res_valid at E2).

## Test plan
The bench instantiates the team's 8-bit load/shift register driven by the sh_* outputs, with sh_q fed back.
- cmd_data=0x96, count=3, asr=0 → sh_load_n low for exactly 1 cycle, sh_shift high for exactly 3 cycles, res_data=0x12, res_valid at E5.
- cmd_data=0x96, count=3, asr=1 → res_data=0xF2, res_valid at E5.
- cmd_data=0x96, count=12, asr=1 → clamped to 8 shifts, res_data=0xFF; with asr=0 → res_data=0x00.
- cmd_data=0x5A, count=0 → res_data=0x5A. res_valid at E2 with the macro undefined; at E0 with SHIFT_SEQ_ZERO_SKIP_EN, with sh_load_n never low.
- res_ready held low 5 cycles after res_valid → res_data is stable, cmd_ready=0, and a held cmd_valid is not accepted. Raising res_ready gives cmd_ready=1 on the next cycle.
- reset_n pulsed low during the second SHIFT cycle of a count=5 command → all outputs at reset values within the same cycle, no res_valid, and a new command is accepted normally afterwards.
